// File: rtl/cgra_config_pkg.sv
// Shared types and width helpers for the CGRA configuration chain loader.
package cgra_config_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } cfg_load_state_t;

  localparam int CFG_DEFAULT_WORD_WIDTH = 32;
  localparam int CFG_DEFAULT_TOTAL_BITS = 64;

  // Bits needed to hold a count from 0 up to and including max_count.
  function automatic int cfg_count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/config_word_shifter.sv
// Word-wide PISO/SIPO pair sharing one bit counter: the outgoing word is
// shifted out LSB first while the returning chain bits fill the readback
// word from index 0 upwards.
module config_word_shifter
  import cgra_config_pkg::*;
#(
  parameter int WORD_WIDTH = CFG_DEFAULT_WORD_WIDTH
) (
  input  logic                                   Config_Clock,
  input  logic                                   Config_Reset,
  input  logic                                   load,
  input  logic [WORD_WIDTH-1:0]                  load_data,
  input  logic                                   shift,
  input  logic                                   serial_in,
  output logic                                   serial_out,
  output logic [WORD_WIDTH-1:0]                  capture_word,
  output logic [cfg_count_width(WORD_WIDTH)-1:0] word_bit
);

  localparam int BIT_CNT_W = cfg_count_width(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] piso;
  logic [WORD_WIDTH-1:0] sipo;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  assign capture_word = sipo | (WORD_WIDTH'(serial_in) << bit_cnt);
  assign serial_out   = piso[0];
  assign word_bit     = bit_cnt;

  // Load a fresh word (clearing readback so unused upper bits read 0), or shift one bit.
  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      piso    <= '0;
      sipo    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      piso    <= load_data;
      sipo    <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      piso    <= piso >> 1;
      sipo    <= capture_word;
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: accepts words over valid/ready, shifts them
// into the configuration chain and returns the displaced chain contents as
// readback words.
module config_loader
  import cgra_config_pkg::*;
#(
  parameter int WORD_WIDTH = CFG_DEFAULT_WORD_WIDTH,
  parameter int TOTAL_BITS = CFG_DEFAULT_TOTAL_BITS
) (
  input  logic                  Config_Clock,
  input  logic                  Config_Reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ConfigOut,
  output logic                  shift_en,
  input  logic                  ChainIn,
  output logic [WORD_WIDTH-1:0] rb_word,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int BIT_CNT_W  = cfg_count_width(WORD_WIDTH);
  localparam int LEFT_CNT_W = cfg_count_width(TOTAL_BITS);

  cfg_load_state_t        state;
  cfg_load_state_t        state_next;
  logic [LEFT_CNT_W-1:0]  bits_left;
  logic [BIT_CNT_W-1:0]   nbits;
  logic [BIT_CNT_W-1:0]   word_bit;
  logic [WORD_WIDTH-1:0]  capture_word;
  logic                   piso_bit;
  logic                   accept;
  logic                   shifting;
  logic                   last_bit;

  assign accept   = (state == LOAD) && word_valid;
  assign shifting = (state == SHIFT);
  assign last_bit = (word_bit + BIT_CNT_W'(1)) == nbits;

  config_word_shifter #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shifter (
    .Config_Clock (Config_Clock),
    .Config_Reset (Config_Reset),
    .load         (accept),
    .load_data    (word_data),
    .shift        (shifting),
    .serial_in    (ChainIn),
    .serial_out   (piso_bit),
    .capture_word (capture_word),
    .word_bit     (word_bit)
  );

  // State register.
  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; outputs depend on state and flopped PISO bit only.
  always_comb begin
    state_next = state;
    word_ready = 1'b0;
    shift_en   = 1'b0;
    ConfigOut  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (word_valid) state_next = SHIFT;
      end
      SHIFT: begin
        shift_en  = 1'b1;
        ConfigOut = piso_bit;
        busy      = 1'b1;
        if (last_bit) begin
          state_next = (bits_left == LEFT_CNT_W'(1)) ? DONE : LOAD;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit bookkeeping per load and per word, plus the one-cycle readback pulse.
  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      bits_left <= '0;
      nbits     <= '0;
      rb_valid  <= 1'b0;
      rb_word   <= '0;
    end else begin
      rb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) bits_left <= LEFT_CNT_W'(TOTAL_BITS);
        end
        LOAD: begin
          if (word_valid) begin
            if (32'(bits_left) >= WORD_WIDTH) nbits <= BIT_CNT_W'(WORD_WIDTH);
            else                              nbits <= BIT_CNT_W'(bits_left);
          end
        end
        SHIFT: begin
          bits_left <= bits_left - LEFT_CNT_W'(1);
          if (last_bit) begin
            rb_valid <= 1'b1;
            rb_word  <= capture_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader with a behavioural chain of TOTAL_BITS flops.
module tb_config_loader;

  localparam int W  = 8;
  localparam int T  = 20;
  localparam int NW = (T + W - 1) / W;

  logic          Config_Clock = 1'b0;
  logic          Config_Reset;
  logic          start;
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic          word_ready;
  logic          ConfigOut;
  logic          shift_en;
  logic          ChainIn;
  logic [W-1:0]  rb_word;
  logic          rb_valid;
  logic          busy;
  logic          done;

  logic [T-1:0]  chain;
  logic [W-1:0]  curWords  [NW];
  logic [W-1:0]  prevWords [NW];
  int            stallBefore [NW];
  bit            pulseStarts;

  int compared   = 0;
  int mismatched = 0;

  always #5 Config_Clock = ~Config_Clock;

  config_loader #(
    .WORD_WIDTH (W),
    .TOTAL_BITS (T)
  ) dut (
    .Config_Clock (Config_Clock),
    .Config_Reset (Config_Reset),
    .start        (start),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .ConfigOut    (ConfigOut),
    .shift_en     (shift_en),
    .ChainIn      (ChainIn),
    .rb_word      (rb_word),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .done         (done)
  );

  // Configuration chain: head takes ConfigOut, tail drives ChainIn, shares reset.
  assign ChainIn = chain[T-1];
  always @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset)  chain <= '0;
    else if (shift_en) chain <= {chain[T-2:0], ConfigOut};
  end

  function automatic int nbitsOf(input int k);
    int left;
    left = T - k * W;
    return (left < W) ? left : W;
  endfunction

  function automatic logic [W-1:0] maskOf(input int k);
    logic [W-1:0] m;
    m = '0;
    for (int b = 0; b < nbitsOf(k); b++) m[b] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllQuiet(input string tag);
    checkOutput($sformatf("%s word_ready", tag), 32'(word_ready), 32'd0);
    checkOutput($sformatf("%s ConfigOut", tag),  32'(ConfigOut),  32'd0);
    checkOutput($sformatf("%s shift_en", tag),   32'(shift_en),   32'd0);
    checkOutput($sformatf("%s rb_valid", tag),   32'(rb_valid),   32'd0);
    checkOutput($sformatf("%s busy", tag),       32'(busy),       32'd0);
    checkOutput($sformatf("%s done", tag),       32'(done),       32'd0);
    checkOutput($sformatf("%s rb_word", tag),    32'(rb_word),    32'd0);
  endtask

  // One full load; expectations come from handshake times and word/bit arithmetic.
  task automatic applyStimulus(input string name, input bit checkMask, input int fixedDone);
    int           cyc, k, stallLeft, totalStall, doneCycle, doneCount, nOut, expDone;
    int           idleCfgViol, stallViol, pulseViol;
    int           hsCycle [NW];
    logic [511:0] obsShift, expShift, obsRb, expRb, obsBusy, expBusy;
    logic [T-1:0] obsStream, expStream, expChain;
    logic [W-1:0] rbq [$];
    logic         prevRb;

    obsShift = '0; expShift = '0; obsRb = '0; expRb = '0; obsBusy = '0; expBusy = '0;
    obsStream = '0; expStream = '0; expChain = '0;
    idleCfgViol = 0; stallViol = 0; pulseViol = 0; prevRb = 1'b0;
    totalStall = 0; doneCycle = -1; doneCount = 0; nOut = 0;
    for (int i = 0; i < NW; i++) hsCycle[i] = -1;
    for (int i = 0; i < NW; i++)
      for (int b = 0; b < nbitsOf(i); b++) expStream[i*W + b] = curWords[i][b];

    start = 1'b1; word_valid = 1'b0; word_data = '0;
    cyc = 0; k = 0; stallLeft = stallBefore[0];
    while (cyc < 400 && (doneCycle < 0 || cyc < doneCycle + 3)) begin
      @(posedge Config_Clock);
      cyc++;
      @(negedge Config_Clock);
      if (shift_en) begin
        obsShift[cyc] = 1'b1;
        if (nOut < T) obsStream[nOut] = ConfigOut;
        nOut++;
      end else if (ConfigOut !== 1'b0) begin
        idleCfgViol++;
      end
      if (rb_valid) begin
        obsRb[cyc] = 1'b1;
        rbq.push_back(rb_word);
        if (prevRb) pulseViol++;
      end
      prevRb = rb_valid;
      obsBusy[cyc] = busy;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
      end

      start = 1'b0;
      if (word_ready && k < NW) begin
        if (stallLeft > 0) begin
          word_valid = 1'b0;
          word_data  = W'($urandom);
          stallLeft--;
          totalStall++;
          if (shift_en || ConfigOut) stallViol++;
        end else begin
          word_valid = 1'b1;
          word_data  = curWords[k];
          hsCycle[k] = cyc;
          k++;
          if (k < NW) stallLeft = stallBefore[k];
        end
      end else begin
        word_valid = 1'($urandom_range(0, 1));
        word_data  = W'($urandom);
        if (pulseStarts && (done || (shift_en && $urandom_range(0, 2) == 0))) start = 1'b1;
      end
    end
    start = 1'b0; word_valid = 1'b0;

    expDone = 1 + totalStall;
    for (int i = 0; i < NW; i++) expDone += nbitsOf(i) + 1;
    for (int i = 0; i < NW; i++) begin
      if (hsCycle[i] >= 0) begin
        for (int c = hsCycle[i] + 1; c <= hsCycle[i] + nbitsOf(i); c++) expShift[c] = 1'b1;
        expRb[hsCycle[i] + nbitsOf(i) + 1] = 1'b1;
      end
    end
    for (int c = 1; c <= cyc; c++) expBusy[c] = (c < expDone);
    for (int i = 0; i < T; i++) expChain[T-1-i] = expStream[i];

    checkOutput($sformatf("%s done seen", name),        32'(doneCount > 0), 32'd1);
    checkOutput($sformatf("%s done cycle", name),       32'(doneCycle), 32'(expDone));
    checkOutput($sformatf("%s done count", name),       32'(doneCount), 32'd1);
    checkOutput($sformatf("%s handshakes", name),       32'(k), 32'(NW));
    checkOutput($sformatf("%s shift_en timing", name),  32'($countones(obsShift ^ expShift)), 32'd0);
    checkOutput($sformatf("%s rb_valid timing", name),  32'($countones(obsRb ^ expRb)), 32'd0);
    checkOutput($sformatf("%s busy timing", name),      32'($countones(obsBusy ^ expBusy)), 32'd0);
    checkOutput($sformatf("%s ConfigOut idle", name),   32'(idleCfgViol), 32'd0);
    checkOutput($sformatf("%s stall quiet", name),      32'(stallViol), 32'd0);
    checkOutput($sformatf("%s rb pulse width", name),   32'(pulseViol), 32'd0);
    checkOutput($sformatf("%s bits shifted", name),     32'(nOut), 32'(T));
    checkOutput($sformatf("%s serial stream", name),    32'(obsStream), 32'(expStream));
    checkOutput($sformatf("%s chain contents", name),   32'(chain), 32'(expChain));
    checkOutput($sformatf("%s readback count", name),   32'(rbq.size()), 32'(NW));
    for (int i = 0; i < NW && i < rbq.size(); i++)
      checkOutput($sformatf("%s readback %0d", name, i), 32'(rbq[i]), 32'(prevWords[i] & maskOf(i)));
    if (checkMask)      checkOutput($sformatf("%s shift cycles", name), obsShift[31:0], 32'h00F7_FBFC);
    if (fixedDone >= 0) checkOutput($sformatf("%s done at", name), 32'(doneCycle), 32'(fixedDone));

    for (int i = 0; i < NW; i++) prevWords[i] = curWords[i];
  endtask

  task automatic randomLoad(input bit forceLastFF);
    for (int i = 0; i < NW; i++) begin
      curWords[i]    = W'($urandom);
      stallBefore[i] = $urandom_range(0, 3);
    end
    if (forceLastFF) curWords[NW-1] = 8'hFF;
  endtask

  // Reset asserted in the middle of SHIFT must clear everything at once.
  task automatic resetMidLoad();
    int  waitCyc;
    bit  reached;
    start = 1'b1; word_valid = 1'b1; word_data = W'($urandom);
    reached = 1'b0; waitCyc = 0;
    while (!reached && waitCyc < 20) begin
      @(posedge Config_Clock);
      @(negedge Config_Clock);
      start = 1'b0;
      waitCyc++;
      if (shift_en) reached = 1'b1;
    end
    checkOutput("midload shift reached", 32'(reached), 32'd1);
    #2 Config_Reset = 1'b1;
    #1 checkAllQuiet("midload reset");
    @(negedge Config_Clock);
    Config_Reset = 1'b0;
    word_valid = 1'b0;
    @(posedge Config_Clock);
    @(negedge Config_Clock);
    checkOutput("post reset word_ready", 32'(word_ready), 32'd0);
    checkOutput("post reset busy", 32'(busy), 32'd0);
    for (int i = 0; i < NW; i++) prevWords[i] = '0;
  endtask

  initial begin
    Config_Reset = 1'b1;
    start = 1'b0; word_valid = 1'b0; word_data = '0;
    pulseStarts = 1'b1;
    for (int i = 0; i < NW; i++) begin
      prevWords[i] = '0;
      stallBefore[i] = 0;
    end
    repeat (2) @(negedge Config_Clock);
    checkAllQuiet("reset");
    Config_Reset = 1'b0;
    @(negedge Config_Clock);

    curWords[0] = 8'hA5; curWords[1] = 8'h3C; curWords[2] = 8'h0F;
    applyStimulus("loadA", 1'b1, 24);

    curWords[0] = 8'h11; curWords[1] = 8'h22; curWords[2] = 8'h03;
    stallBefore[0] = 0; stallBefore[1] = 5; stallBefore[2] = 0;
    applyStimulus("loadB", 1'b0, 29);

    randomLoad(1'b1);
    applyStimulus("loadC", 1'b0, -1);
    randomLoad(1'b0);
    applyStimulus("loadD", 1'b0, -1);

    resetMidLoad();

    for (int n = 0; n < 4; n++) begin
      randomLoad(1'b0);
      applyStimulus($sformatf("rand%0d", n), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
